// File: rtl/oy_pkg.sv
// Shared constants for the round-vote evaluator: widths, the legal vote ceiling
// and the FSM state codes.
package oy_pkg;

  localparam int OY_MAX   = 4;
  localparam int SAYI_W   = 3;
  localparam int TUR_W    = 4;
  localparam int TOPLAM_W = 6;
  localparam int DURUM_W  = 2;

  localparam logic [DURUM_W-1:0] BOS   = 2'd0;
  localparam logic [DURUM_W-1:0] TOPLA = 2'd1;
  localparam logic [DURUM_W-1:0] KARAR = 2'd2;
  localparam logic [DURUM_W-1:0] SONUC = 2'd3;

endpackage

// File: rtl/oy_biriktirici.sv
// Session counters: accepted rounds, summed yes-votes and rounds at or above ESIK.
// temizle has priority over kabul_et so a restart always wins over a sample.
module oy_biriktirici
  import oy_pkg::*;
#(
  parameter int ESIK = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                temizle,
  input  logic                kabul_et,
  input  logic [SAYI_W-1:0]   oy_sayisi,
  output logic [TUR_W-1:0]    tur_no,
  output logic [TOPLAM_W-1:0] toplam_oy,
  output logic [TUR_W-1:0]    gecen_tur
);

  logic [TUR_W-1:0]    tur_q, tur_d;
  logic [TOPLAM_W-1:0] toplam_q, toplam_d;
  logic [TUR_W-1:0]    gecen_q, gecen_d;

  always_comb begin
    tur_d    = tur_q;
    toplam_d = toplam_q;
    gecen_d  = gecen_q;
    if (temizle) begin
      tur_d    = '0;
      toplam_d = '0;
      gecen_d  = '0;
    end else if (kabul_et) begin
      tur_d    = tur_q + TUR_W'(1);
      toplam_d = toplam_q + TOPLAM_W'(oy_sayisi);
      if (oy_sayisi >= SAYI_W'(ESIK)) gecen_d = gecen_q + TUR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tur_q    <= '0;
      toplam_q <= '0;
      gecen_q  <= '0;
    end else begin
      tur_q    <= tur_d;
      toplam_q <= toplam_d;
      gecen_q  <= gecen_d;
    end
  end

  assign tur_no    = tur_q;
  assign toplam_oy = toplam_q;
  assign gecen_tur = gecen_q;

endmodule

// File: rtl/oy_degerlendirici.sv
// Collects TUR_SAYISI round counts, then decides by strict majority of passing rounds.
// Handshake: a sample is taken on any rising edge where oy_gecerli=1 in TOPLA; there is no back-pressure.
module oy_degerlendirici
  import oy_pkg::*;
#(
  parameter int TUR_SAYISI = 4,
  parameter int ESIK       = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tur_baslat,
  input  logic                oy_gecerli,
  input  logic [SAYI_W-1:0]   oy_sayisi,
  output logic                mesgul,
  output logic [TUR_W-1:0]    tur_no,
  output logic [TOPLAM_W-1:0] toplam_oy,
  output logic [TUR_W-1:0]    gecen_tur,
  output logic                kabul,
  output logic                red,
  output logic                oturum_bitti,
  output logic                hata,
  output logic [DURUM_W-1:0]  durum
);

  logic [DURUM_W-1:0] durum_q, durum_d;
  logic kabul_q, kabul_d, red_q, red_d, bitti_q, bitti_d, hata_q, hata_d;
  logic temizle, kabul_et, gecerli_sayi, son_tur, kazandi;

  assign gecerli_sayi = (oy_sayisi <= SAYI_W'(OY_MAX));
  assign son_tur      = (tur_no == TUR_W'(TUR_SAYISI - 1));
  assign kazandi      = ({1'b0, gecen_tur, 1'b0} > 6'(TUR_SAYISI));

  always_comb begin
    durum_d  = durum_q;
    kabul_d  = kabul_q;
    red_d    = red_q;
    hata_d   = hata_q;
    bitti_d  = 1'b0;
    temizle  = 1'b0;
    kabul_et = 1'b0;
    // A start is honoured everywhere except the one-cycle decision state.
    if (tur_baslat && durum_q != KARAR) begin
      durum_d = TOPLA;
      temizle = 1'b1;
      kabul_d = 1'b0;
      red_d   = 1'b0;
      hata_d  = 1'b0;
    end else begin
      case (durum_q)
        TOPLA: begin
          if (oy_gecerli) begin
            if (gecerli_sayi) begin
              kabul_et = 1'b1;
              if (son_tur) durum_d = KARAR;
            end else begin
              hata_d = 1'b1;
            end
          end
        end
        KARAR: begin
          durum_d = SONUC;
          kabul_d = kazandi;
          red_d   = !kazandi;
          bitti_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      durum_q <= BOS;
      kabul_q <= 1'b0;
      red_q   <= 1'b0;
      bitti_q <= 1'b0;
      hata_q  <= 1'b0;
    end else begin
      durum_q <= durum_d;
      kabul_q <= kabul_d;
      red_q   <= red_d;
      bitti_q <= bitti_d;
      hata_q  <= hata_d;
    end
  end

  oy_biriktirici #(.ESIK(ESIK)) u_biriktirici (
    .clk       (clk),
    .rst       (rst),
    .temizle   (temizle),
    .kabul_et  (kabul_et),
    .oy_sayisi (oy_sayisi),
    .tur_no    (tur_no),
    .toplam_oy (toplam_oy),
    .gecen_tur (gecen_tur)
  );

  assign mesgul       = (durum_q == TOPLA) || (durum_q == KARAR);
  assign kabul        = kabul_q;
  assign red          = red_q;
  assign oturum_bitti = bitti_q;
  assign hata         = hata_q;
  assign durum        = durum_q;

endmodule
